rtc_lap_capture: RTL and testbench
==================================

RTC_LAP_CAPTURE -- requirements
Module: rtc_lap_capture

Interface
REQ-001 SHALL have parameter LGFIFO, default 3, meaning log2 of lap-FIFO depth (8 entries).
REQ-002 SHALL have one clock; reset is asynchronous and active-high: i_clk in 1 (rising edge), i_reset in 1 (async, active-high).
REQ-003 SHALL have ports: i_wb_stb in 1 (bus strobe); i_wb_we in 1 (write); i_wb_addr in 2 (register select); i_wb_data in 32 (write data).
REQ-004 SHALL have ports: o_wb_ack out 1 (acknowledge); o_wb_data out 32 (read data).
REQ-005 SHALL have ports: i_sw_value in 31 (stopwatch BCD value); i_sw_running in 1 (stopwatch running).
REQ-006 SHALL have ports: o_sw_start, o_sw_stop, o_sw_clear out 1 each (single-cycle stopwatch commands).
REQ-007 SHALL have ports: i_lap in 1 (synchronous single-cycle lap pulse); o_int out 1 (lap data pending).

Function
REQ-008 o_wb_ack SHALL assert exactly one cycle after every i_wb_stb; o_wb_data SHALL be registered on that same edge.
REQ-009 Write addr 0: bit0=1 -> o_sw_start pulse; bit0=0 -> o_sw_stop pulse; bit1=1 with bit0=0, or bit1=1 with i_sw_running low -> o_sw_clear pulse; bit2=1 -> lap request. All pulses one cycle, starting the cycle after stb.
REQ-010 Read addr 0 SHALL return {i_sw_running, overflow, 2'b0, count[LGFIFO:0] zero-extended to 28 bits}.
REQ-011 Read addr 1 SHALL return {1'b0, i_sw_value} sampled on the stb cycle.
REQ-012 Read addr 2 SHALL return {1'b1, head entry} and pop one entry when non-empty; when empty it SHALL return 32'h0 and not pop.
REQ-013 Write addr 3 SHALL empty the FIFO and clear overflow; read addr 3 SHALL return the same as addr 0 without side effect.
REQ-014 A lap event (i_lap high, or REQ-009 bit2) SHALL push i_sw_value only while i_sw_running is high; otherwise it is ignored.
REQ-015 Push when full SHALL be dropped and set sticky overflow; FIFO contents unchanged.
REQ-016 Simultaneous push and pop when full SHALL both succeed, count unchanged, returned entry is the old head.
REQ-017 Simultaneous push and pop when empty SHALL return 32'h0, push succeeds, count becomes 1.
REQ-018 i_lap and a bit2 write in the same cycle SHALL count as one lap event.
REQ-019 Write addr 3 concurrent with a lap event SHALL leave FIFO empty (clear wins).
REQ-020 count SHALL range 0..2**LGFIFO; pointers SHALL wrap modulo 2**LGFIFO.
REQ-021 o_int SHALL equal (count != 0) registered, updating one cycle after count changes.
REQ-022 Write with o_sw_clear SHALL NOT affect FIFO contents.

Reset
REQ-023 On i_reset, asynchronously: o_wb_ack=0, o_wb_data=0, command pulses=0, count=0, pointers=0, overflow=0, o_int=0.
REQ-024 Reset mid-transaction SHALL drop the pending ack; FIFO RAM contents need not be cleared.

Structure
REQ-025 Register address constants (CTRL=0, VALUE=1, LAP=2, STAT=3) and control bit positions SHALL live in shared package rtc_pkg.
REQ-026 FIFO storage and pointers SHALL be one sub-module rtc_lap_fifo (params LGFIFO, width 31; push, pop, flush, full, empty, count).
REQ-027 Implementation SHALL fit 120-400 lines total.

Verification
REQ-028 Write addr0=1, i_sw_running=1, i_sw_value=31'h0000_0123, pulse i_lap -> o_sw_start one pulse; read addr2 -> 32'h8000_0123; read addr0 count=0.
REQ-029 Running, 9 laps with values 1..9 -> reads return 8000_0001..8000_0008, overflow=1, ninth dropped; write addr3 -> count 0, overflow 0.
REQ-030 FIFO full (8), i_lap and addr2 read same cycle -> returns oldest entry, count stays 8, overflow stays 0.
REQ-031 i_sw_running=0, i_lap pulse -> count stays 0; write addr0=3 while running -> o_sw_start only, no o_sw_clear; write addr0=2 -> o_sw_stop and o_sw_clear.
REQ-032 Assert i_reset asynchronously mid-strobe with count=3 -> o_wb_ack=0 same cycle, count=0, o_int=0.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared definitions for the stopwatch lap-capture block.
// Holds the bus register map, the control-register bit positions and a
// helper that packs the status word returned by the CTRL and STAT reads.
package rtc_pkg;

   typedef enum logic [1:0] {
      REG_CTRL  = 2'd0,
      REG_VALUE = 2'd1,
      REG_LAP   = 2'd2,
      REG_STAT  = 2'd3
   } rtc_reg_e;

   localparam int CTRL_START_BIT = 0;
   localparam int CTRL_CLEAR_BIT = 1;
   localparam int CTRL_LAP_BIT   = 2;

   localparam int SW_W = 31;

   // Status word: {running, overflow, 2'b00, count zero-extended to 28 bits}
   function automatic logic [31:0] stat_word(input logic running,
                                             input logic overflow,
                                             input logic [27:0] count);
      return {running, overflow, 2'b00, count};
   endfunction

endpackage

// File: rtl/rtc_lap_fifo.sv
// Lap FIFO: 2**LGFIFO entries of WIDTH bits with occupancy count.
// Ports:
//   i_clk, i_reset  clock, async active-high reset (pointers/count only)
//   i_push, i_data  write request and data
//   i_pop           read request; o_data always shows the head entry
//   i_flush         empties the FIFO; overrides push and pop
//   o_full, o_empty, o_count  occupancy status (count 0..2**LGFIFO)
module rtc_lap_fifo #(
   parameter int LGFIFO = 3,
   parameter int WIDTH  = 31
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic              i_flush,
   input  logic [WIDTH-1:0]  i_data,
   output logic [WIDTH-1:0]  o_data,
   output logic              o_full,
   output logic              o_empty,
   output logic [LGFIFO:0]   o_count
);

   localparam int DEPTH = 1 << LGFIFO;

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [LGFIFO-1:0] wr_ptr_q, wr_ptr_d;
   logic [LGFIFO-1:0] rd_ptr_q, rd_ptr_d;
   logic [LGFIFO:0]   count_q, count_d;
   logic              do_push, do_pop;

   always_comb begin
      o_full  = (count_q == (LGFIFO+1)'(DEPTH));
      o_empty = (count_q == '0);
      do_pop  = i_pop & ~o_empty & ~i_flush;
      // A pop in the same cycle frees the slot, so push into a full FIFO succeeds
      do_push = i_push & (~o_full | do_pop) & ~i_flush;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (i_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + LGFIFO'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + LGFIFO'(1);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + (LGFIFO+1)'(1);
            2'b01:   count_d = count_q - (LGFIFO+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; only the pointers define valid contents
   always_ff @(posedge i_clk) begin
      if (do_push) mem[wr_ptr_q] <= i_data;
   end

   assign o_data  = mem[rd_ptr_q];
   assign o_count = count_q;

endmodule

// File: rtl/rtc_lap_capture.sv
// Stopwatch lap-capture peripheral with a 4-register single-cycle bus.
// Ports:
//   i_clk, i_reset                clock, async active-high reset
//   i_wb_stb/we/addr/data         bus request (ack exactly one cycle later)
//   o_wb_ack, o_wb_data           registered acknowledge and read data
//   i_sw_value, i_sw_running      stopwatch BCD value and run state
//   o_sw_start/stop/clear         single-cycle stopwatch commands
//   i_lap                         lap pulse; captures i_sw_value while running
//   o_int                         lap data pending (registered count != 0)
module rtc_lap_capture
   import rtc_pkg::*;
#(
   parameter int LGFIFO = 3
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_wb_stb,
   input  logic        i_wb_we,
   input  logic [1:0]  i_wb_addr,
   input  logic [31:0] i_wb_data,
   output logic        o_wb_ack,
   output logic [31:0] o_wb_data,
   input  logic [30:0] i_sw_value,
   input  logic        i_sw_running,
   output logic        o_sw_start,
   output logic        o_sw_stop,
   output logic        o_sw_clear,
   input  logic        i_lap,
   output logic        o_int
);

   rtc_reg_e        reg_sel;
   logic            wr_ctrl, wr_stat, rd_lap;
   logic            lap_evt, push_req, drop;
   logic [31:0]     rd_data;
   logic [SW_W-1:0] fifo_data;
   logic            fifo_full, fifo_empty;
   logic [LGFIFO:0] fifo_count;

   logic        ack_q, ack_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic        start_q, start_d;
   logic        stop_q, stop_d;
   logic        clear_q, clear_d;
   logic        overflow_q, overflow_d;
   logic        int_q, int_d;

   logic unused_wdata;
   assign unused_wdata = ^i_wb_data[31:3];

   always_comb begin
      reg_sel  = rtc_reg_e'(i_wb_addr);
      wr_ctrl  = i_wb_stb & i_wb_we & (reg_sel == REG_CTRL);
      wr_stat  = i_wb_stb & i_wb_we & (reg_sel == REG_STAT);
      rd_lap   = i_wb_stb & ~i_wb_we & (reg_sel == REG_LAP);

      // External pulse and bus lap request merge into a single event
      lap_evt  = i_lap | (wr_ctrl & i_wb_data[CTRL_LAP_BIT]);
      push_req = lap_evt & i_sw_running;
      // Dropped only when full with no concurrent pop; a flush discards it anyway
      drop     = push_req & fifo_full & ~rd_lap & ~wr_stat;

      overflow_d = wr_stat ? 1'b0 : (overflow_q | drop);
      int_d      = (fifo_count != '0);
      ack_d      = i_wb_stb;

      start_d = wr_ctrl & i_wb_data[CTRL_START_BIT];
      stop_d  = wr_ctrl & ~i_wb_data[CTRL_START_BIT];
      // Clear is honoured together with a stop, or whenever the watch is idle
      clear_d = wr_ctrl & i_wb_data[CTRL_CLEAR_BIT] &
                (~i_wb_data[CTRL_START_BIT] | ~i_sw_running);

      rd_data = 32'h0;
      case (reg_sel)
         REG_CTRL, REG_STAT: rd_data = stat_word(i_sw_running, overflow_q, 28'(fifo_count));
         REG_VALUE:          rd_data = {1'b0, i_sw_value};
         REG_LAP:            rd_data = fifo_empty ? 32'h0 : {1'b1, fifo_data};
         default:            rd_data = 32'h0;
      endcase
      wb_data_d = (i_wb_stb & ~i_wb_we) ? rd_data : 32'h0;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         ack_q      <= 1'b0;
         wb_data_q  <= 32'h0;
         start_q    <= 1'b0;
         stop_q     <= 1'b0;
         clear_q    <= 1'b0;
         overflow_q <= 1'b0;
         int_q      <= 1'b0;
      end else begin
         ack_q      <= ack_d;
         wb_data_q  <= wb_data_d;
         start_q    <= start_d;
         stop_q     <= stop_d;
         clear_q    <= clear_d;
         overflow_q <= overflow_d;
         int_q      <= int_d;
      end
   end

   rtc_lap_fifo #(
      .LGFIFO (LGFIFO),
      .WIDTH  (SW_W)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_push  (push_req),
      .i_pop   (rd_lap),
      .i_flush (wr_stat),
      .i_data  (i_sw_value),
      .o_data  (fifo_data),
      .o_full  (fifo_full),
      .o_empty (fifo_empty),
      .o_count (fifo_count)
   );

   assign o_wb_ack   = ack_q;
   assign o_wb_data  = wb_data_q;
   assign o_sw_start = start_q;
   assign o_sw_stop  = stop_q;
   assign o_sw_clear = clear_q;
   assign o_int      = int_q;

endmodule

// File: tb/tb_rtc_lap_capture.sv
// Scoreboard bench for rtc_lap_capture: each bus transaction pushes its
// expected read data and command pulses; a monitor pops and compares on ack.
module tb_rtc_lap_capture;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_wb_stb = 1'b0;
   logic        i_wb_we = 1'b0;
   logic [1:0]  i_wb_addr = 2'd0;
   logic [31:0] i_wb_data = 32'h0;
   logic        o_wb_ack;
   logic [31:0] o_wb_data;
   logic [30:0] i_sw_value = 31'h0;
   logic        i_sw_running = 1'b0;
   logic        o_sw_start, o_sw_stop, o_sw_clear;
   logic        i_lap = 1'b0;
   logic        o_int;

   always #5 clk = ~clk;

   rtc_lap_capture #(.LGFIFO(3)) dut (
      .i_clk        (clk),
      .i_reset      (rst),
      .i_wb_stb     (i_wb_stb),
      .i_wb_we      (i_wb_we),
      .i_wb_addr    (i_wb_addr),
      .i_wb_data    (i_wb_data),
      .o_wb_ack     (o_wb_ack),
      .o_wb_data    (o_wb_data),
      .i_sw_value   (i_sw_value),
      .i_sw_running (i_sw_running),
      .o_sw_start   (o_sw_start),
      .o_sw_stop    (o_sw_stop),
      .o_sw_clear   (o_sw_clear),
      .i_lap        (i_lap),
      .o_int        (o_int)
   );

   typedef struct {
      string       name;
      logic [31:0] data;
      logic [2:0]  pulses;   // {start, stop, clear}
   } exp_t;

   exp_t sb[$];
   int   pass_cnt  = 0;
   int   total_cnt = 0;

   localparam logic [1:0] A_CTRL = 2'd0, A_VALUE = 2'd1, A_LAP = 2'd2, A_STAT = 2'd3;

   function automatic logic [31:0] st(input logic run, input logic ovf, input int cnt);
      return {run, ovf, 2'b00, 28'(cnt)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Monitor: every ack consumes one scoreboard entry
   always @(negedge clk) begin
      if (o_wb_ack === 1'b1) begin
         if (sb.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_ack: got ack with empty scoreboard at %0t", $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, "_data"}, o_wb_data, e.data);
            check({e.name, "_pulses"}, {29'h0, o_sw_start, o_sw_stop, o_sw_clear},
                  {29'h0, e.pulses});
         end
      end
   end

   task automatic bus(input logic we, input logic [1:0] addr, input logic [31:0] data,
                      input logic lap, input logic [31:0] exp_data,
                      input logic [2:0] exp_p, input string name);
      exp_t e;
      @(negedge clk);
      i_wb_stb  = 1'b1;
      i_wb_we   = we;
      i_wb_addr = addr;
      i_wb_data = data;
      i_lap     = lap;
      e.name = name; e.data = exp_data; e.pulses = exp_p;
      sb.push_back(e);
      @(negedge clk);
      i_wb_stb = 1'b0;
      i_wb_we  = 1'b0;
      i_lap    = 1'b0;
   endtask

   task automatic rd(input logic [1:0] addr, input logic [31:0] exp, input string name);
      bus(1'b0, addr, 32'h0, 1'b0, exp, 3'b000, name);
   endtask

   task automatic wr(input logic [1:0] addr, input logic [31:0] data,
                     input logic [2:0] exp_p, input string name);
      bus(1'b1, addr, data, 1'b0, 32'h0, exp_p, name);
   endtask

   task automatic lap_pulse(input logic [30:0] v);
      @(negedge clk);
      i_sw_value = v;
      i_lap      = 1'b1;
      @(negedge clk);
      i_lap = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      check("rst_ack", {31'h0, o_wb_ack}, 32'h0);
      check("rst_data", o_wb_data, 32'h0);
      check("rst_pulses", {29'h0, o_sw_start, o_sw_stop, o_sw_clear}, 32'h0);
      check("rst_int", {31'h0, o_int}, 32'h0);
      rst = 1'b0;

      // Start command, one lap, read back
      i_sw_running = 1'b1;
      i_sw_value   = 31'h123;
      wr(A_CTRL, 32'h1, 3'b100, "start");
      lap_pulse(31'h123);
      @(negedge clk);
      check("int_after_lap", {31'h0, o_int}, 32'h1);
      rd(A_VALUE, 32'h0000_0123, "value");
      rd(A_LAP, 32'h8000_0123, "lap_first");
      rd(A_CTRL, st(1, 0, 0), "stat_after_pop");
      check("int_after_pop", {31'h0, o_int}, 32'h0);

      // Nine laps into an eight-deep FIFO
      for (int i = 1; i <= 9; i++) lap_pulse(31'(i));
      rd(A_CTRL, st(1, 1, 8), "ovf_ctrl");
      rd(A_STAT, st(1, 1, 8), "ovf_stat");
      rd(A_LAP, 32'h8000_0001, "ovf_pop1");
      rd(A_LAP, 32'h8000_0002, "ovf_pop2");
      rd(A_CTRL, st(1, 1, 6), "ovf_sticky");
      wr(A_STAT, 32'h0, 3'b000, "flush");
      rd(A_CTRL, st(1, 0, 0), "after_flush");
      rd(A_LAP, 32'h0, "empty_pop");

      // Push and pop together while full
      for (int i = 0; i < 8; i++) lap_pulse(31'h10 + 31'(i));
      rd(A_CTRL, st(1, 0, 8), "full8");
      i_sw_value = 31'h55;
      bus(1'b0, A_LAP, 32'h0, 1'b1, 32'h8000_0010, 3'b000, "full_pushpop");
      rd(A_CTRL, st(1, 0, 8), "full_after_pp");
      for (int i = 1; i < 8; i++) rd(A_LAP, 32'h8000_0010 + 32'(i), "drain");
      rd(A_LAP, 32'h8000_0055, "drain_last");
      rd(A_LAP, 32'h0, "drain_empty");

      // Push and pop together while empty
      i_sw_value = 31'h66;
      bus(1'b0, A_LAP, 32'h0, 1'b1, 32'h0, 3'b000, "empty_pushpop");
      rd(A_CTRL, st(1, 0, 1), "empty_pp_cnt");
      rd(A_LAP, 32'h8000_0066, "empty_pp_val");

      // i_lap and bit2 write together count once; bit0=0 also stops
      i_sw_value = 31'h77;
      bus(1'b1, A_CTRL, 32'h4, 1'b1, 32'h0, 3'b010, "dual_lap");
      rd(A_CTRL, st(1, 0, 1), "dual_lap_cnt");
      rd(A_LAP, 32'h8000_0077, "dual_lap_val");
      i_sw_value = 31'h78;
      wr(A_CTRL, 32'h5, 3'b100, "bus_lap");
      rd(A_LAP, 32'h8000_0078, "bus_lap_val");

      // Clear command leaves FIFO alone; flush beats concurrent lap
      lap_pulse(31'h79);
      wr(A_CTRL, 32'h2, 3'b011, "stop_clear_fifo");
      rd(A_CTRL, st(1, 0, 1), "clear_keeps_fifo");
      bus(1'b1, A_STAT, 32'h0, 1'b1, 32'h0, 3'b000, "flush_vs_lap");
      rd(A_CTRL, st(1, 0, 0), "flush_wins");

      // Not running: laps ignored, clear allowed with start
      i_sw_running = 1'b0;
      lap_pulse(31'h99);
      wr(A_CTRL, 32'h4, 3'b010, "idle_bus_lap");
      rd(A_CTRL, st(0, 0, 0), "idle_no_push");
      wr(A_CTRL, 32'h3, 3'b101, "idle_start_clear");
      i_sw_running = 1'b1;
      wr(A_CTRL, 32'h3, 3'b100, "run_start_noclr");
      wr(A_CTRL, 32'h2, 3'b011, "run_stop_clear");

      // Async reset mid-transaction with three entries queued
      for (int i = 0; i < 3; i++) lap_pulse(31'h200 + 31'(i));
      @(negedge clk);
      check("int_pre_reset", {31'h0, o_int}, 32'h1);
      i_wb_stb  = 1'b1;
      i_wb_we   = 1'b0;
      i_wb_addr = A_CTRL;
      @(posedge clk);
      #2;
      check("ack_pre_reset", {31'h0, o_wb_ack}, 32'h1);
      rst = 1'b1;
      #1;
      check("ack_async_drop", {31'h0, o_wb_ack}, 32'h0);
      check("data_async_clr", o_wb_data, 32'h0);
      check("int_async_clr", {31'h0, o_int}, 32'h0);
      @(negedge clk);
      i_wb_stb = 1'b0;
      rst      = 1'b0;
      rd(A_CTRL, st(1, 0, 0), "post_reset_cnt");
      rd(A_LAP, 32'h0, "post_reset_empty");

      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         total_cnt++;
         $display("FAIL ack_timeout: %0d responses outstanding, required 0", sb.size());
      end
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
